// File: rtl/rv32i_gcd_host_if.sv
// Host-side job controller for the RV32I core's GCD port: issues operands, infers completion from result stability.
// Optional feature: define GCD_HOST_ZERO_BYPASS_EN to answer jobs with a zero operand directly, without starting the core.
module rv32i_gcd_host_if #(
    parameter int unsigned START_CYCLES   = 2,
    parameter int unsigned MIN_CYCLES     = 8,
    parameter int unsigned STABLE_CYCLES  = 16,
    parameter int unsigned TIMEOUT_CYCLES = 4096,
    parameter int unsigned CNT_W          = 16,
    localparam int unsigned DATA_W        = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_a,
    input  logic [DATA_W-1:0] in_b,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_result,
    output logic              out_timeout,
    output logic              busy,
    output logic              calc_start,
    output logic [DATA_W-1:0] gcd_a,
    output logic [DATA_W-1:0] gcd_b,
    input  logic [DATA_W-1:0] gcd_result
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_START = 2'd1;
    localparam logic [1:0] S_RUN   = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    localparam logic [CNT_W-1:0] START_LAST = CNT_W'(START_CYCLES - 1);
    localparam logic [CNT_W-1:0] MIN_C      = CNT_W'(MIN_CYCLES);
    localparam logic [CNT_W-1:0] STABLE_C   = CNT_W'(STABLE_CYCLES);
    localparam logic [CNT_W-1:0] TIMEOUT_C  = CNT_W'(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] CNT_MAX    = '1;

    logic [1:0]        state_q,       state_d;
    logic [CNT_W-1:0]  start_cnt_q,   start_cnt_d;
    logic [CNT_W-1:0]  elapsed_q,     elapsed_d;
    logic [CNT_W-1:0]  stab_q,        stab_d;
    logic [DATA_W-1:0] prev_q,        prev_d;
    logic              calc_start_q,  calc_start_d;
    logic              out_valid_q,   out_valid_d;
    logic [DATA_W-1:0] out_result_q,  out_result_d;
    logic              out_timeout_q, out_timeout_d;
    logic [DATA_W-1:0] gcd_a_q,       gcd_a_d;
    logic [DATA_W-1:0] gcd_b_q,       gcd_b_d;

    // State and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= S_IDLE;
            start_cnt_q   <= '0;
            elapsed_q     <= '0;
            stab_q        <= '0;
            prev_q        <= '0;
            calc_start_q  <= 1'b0;
            out_valid_q   <= 1'b0;
            out_result_q  <= '0;
            out_timeout_q <= 1'b0;
            gcd_a_q       <= '0;
            gcd_b_q       <= '0;
        end else begin
            state_q       <= state_d;
            start_cnt_q   <= start_cnt_d;
            elapsed_q     <= elapsed_d;
            stab_q        <= stab_d;
            prev_q        <= prev_d;
            calc_start_q  <= calc_start_d;
            out_valid_q   <= out_valid_d;
            out_result_q  <= out_result_d;
            out_timeout_q <= out_timeout_d;
            gcd_a_q       <= gcd_a_d;
            gcd_b_q       <= gcd_b_d;
        end
    end

    // Next-state and registered-output logic
    always_comb begin
        state_d       = state_q;
        start_cnt_d   = start_cnt_q;
        elapsed_d     = elapsed_q;
        stab_d        = stab_q;
        prev_d        = prev_q;
        calc_start_d  = calc_start_q;
        out_valid_d   = out_valid_q;
        out_result_d  = out_result_q;
        out_timeout_d = out_timeout_q;
        gcd_a_d       = gcd_a_q;
        gcd_b_d       = gcd_b_q;

        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    gcd_a_d = in_a;
                    gcd_b_d = in_b;
`ifdef GCD_HOST_ZERO_BYPASS_EN
                    if ((in_a == '0) || (in_b == '0)) begin
                        state_d       = S_DONE;
                        out_valid_d   = 1'b1;
                        out_result_d  = (in_a == '0) ? in_b : in_a;
                        out_timeout_d = 1'b0;
                    end else
`endif
                    begin
                        state_d      = S_START;
                        calc_start_d = 1'b1;
                        start_cnt_d  = '0;
                    end
                end
            end

            S_START: begin
                if (start_cnt_q == START_LAST) begin
                    state_d      = S_RUN;
                    calc_start_d = 1'b0;
                    elapsed_d    = '0;
                    stab_d       = '0;
                    prev_d       = gcd_result;
                end else begin
                    start_cnt_d = start_cnt_q + CNT_W'(1);
                end
            end

            S_RUN: begin
                elapsed_d = elapsed_q + CNT_W'(1);
                if (gcd_result == prev_q) begin
                    stab_d = (stab_q == CNT_MAX) ? stab_q : stab_q + CNT_W'(1);
                end else begin
                    stab_d = '0;
                    prev_d = gcd_result;
                end
                // Stability is checked first so a simultaneous timeout is not flagged
                if ((elapsed_d >= MIN_C) && (stab_d >= STABLE_C)) begin
                    state_d       = S_DONE;
                    out_valid_d   = 1'b1;
                    out_result_d  = gcd_result;
                    out_timeout_d = 1'b0;
                end else if (elapsed_d == TIMEOUT_C) begin
                    state_d       = S_DONE;
                    out_valid_d   = 1'b1;
                    out_result_d  = gcd_result;
                    out_timeout_d = 1'b1;
                end
            end

            S_DONE: begin
                if (out_ready) begin
                    state_d     = S_IDLE;
                    out_valid_d = 1'b0;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign in_ready    = (state_q == S_IDLE);
    assign busy        = (state_q != S_IDLE);
    assign calc_start  = calc_start_q;
    assign out_valid   = out_valid_q;
    assign out_result  = out_result_q;
    assign out_timeout = out_timeout_q;
    assign gcd_a       = gcd_a_q;
    assign gcd_b       = gcd_b_q;

endmodule

// File: tb/tb_rv32i_gcd_host_if.sv
// Self-checking bench for rv32i_gcd_host_if: subtractive GCD core model plus scripted-result instances.
`timescale 1ns/1ps
module tb_rv32i_gcd_host_if;

    localparam int MIN_LAT = 19;  // START_CYCLES + max(MIN, STABLE) + 1

    typedef struct packed {
        logic [31:0] res;
        logic        tmo;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    // Instance 1: default parameters, driven by a GCD core model
    logic        in_valid, out_ready;
    logic [31:0] in_a, in_b;
    logic        in_ready, out_valid, out_timeout, busy, calc_start;
    logic [31:0] out_result, gcd_a, gcd_b, gcd_result;
    logic [31:0] core_ra, core_rb;

    rv32i_gcd_host_if u_dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
        .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result), .out_timeout(out_timeout),
        .busy(busy), .calc_start(calc_start), .gcd_a(gcd_a), .gcd_b(gcd_b), .gcd_result(gcd_result)
    );

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            core_ra    <= '0;
            core_rb    <= '0;
            gcd_result <= '0;
        end else if (calc_start) begin
            core_ra <= gcd_a;
            core_rb <= gcd_b;
        end else begin
            if (core_ra != 0 && core_rb != 0 && core_ra > core_rb) core_ra <= core_ra - core_rb;
            else if (core_ra != 0 && core_rb != 0 && core_rb > core_ra) core_rb <= core_rb - core_ra;
            gcd_result <= (core_ra == 0) ? core_rb : core_ra;
        end
    end

    // Instances 2 (timeout 64) and 3 (timeout 16) share stimulus and a scripted result
    logic        in_valid2, out_ready2;
    logic [31:0] in_a2, in_b2;
    logic        in_ready2, out_valid2, out_timeout2, busy2, calc_start2;
    logic [31:0] out_result2, gcd_a2, gcd_b2;
    logic        in_ready3, out_valid3, out_timeout3, busy3, calc_start3;
    logic [31:0] out_result3, gcd_a3, gcd_b3;
    logic        toggle;
    logic [31:0] const_val;
    logic [15:0] tcnt = '0;
    logic [31:0] res2;

    always @(posedge clk) tcnt <= tcnt + 16'd1;
    assign res2 = toggle ? {16'hA5A5, tcnt} : const_val;

    rv32i_gcd_host_if #(.TIMEOUT_CYCLES(64)) u_dut2 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid2), .in_ready(in_ready2), .in_a(in_a2), .in_b(in_b2),
        .out_valid(out_valid2), .out_ready(out_ready2), .out_result(out_result2), .out_timeout(out_timeout2),
        .busy(busy2), .calc_start(calc_start2), .gcd_a(gcd_a2), .gcd_b(gcd_b2), .gcd_result(res2)
    );

    rv32i_gcd_host_if #(.TIMEOUT_CYCLES(16)) u_dut3 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid2), .in_ready(in_ready3), .in_a(in_a2), .in_b(in_b2),
        .out_valid(out_valid3), .out_ready(out_ready2), .out_result(out_result3), .out_timeout(out_timeout3),
        .busy(busy3), .calc_start(calc_start3), .gcd_a(gcd_a3), .gcd_b(gcd_b3), .gcd_result(res2)
    );

    int   checks = 0;
    int   errors = 0;
    int   cs1 = 0;
    int   cs2 = 0;
    exp_t sb[$];
    exp_t sb2[$];

    always @(negedge clk) begin
        if (calc_start === 1'b1) cs1++;
        if (calc_start2 === 1'b1) cs2++;
    end

    // Drive one job into instance 1 from a negedge; returns at the negedge after the accept edge
    task automatic issue1(input logic [31:0] a, input logic [31:0] b);
        in_a = a;
        in_b = b;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic await1(input int budget, output int n);
        n = 1;
        while (out_valid !== 1'b1 && n < budget) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        in_valid = 1'b0; in_a = '0; in_b = '0; out_ready = 1'b0;
        in_valid2 = 1'b0; in_a2 = '0; in_b2 = '0; out_ready2 = 1'b0;
        toggle = 1'b0; const_val = '0;
        repeat (3) @(negedge clk);
        checks++;
        if ({in_ready, out_valid, out_timeout, busy, calc_start} !== 5'b10000) begin
            errors++;
            $display("FAIL reset_ctrl got %b want 10000", {in_ready, out_valid, out_timeout, busy, calc_start});
        end
        checks++;
        if ({out_result, gcd_a, gcd_b} !== 96'd0) begin
            errors++;
            $display("FAIL reset_data got %h/%h/%h want 0/0/0", out_result, gcd_a, gcd_b);
        end
        checks++;
        if ({in_ready2, out_valid2, out_timeout2, busy2, calc_start2, in_ready3, out_valid3, out_timeout3, busy3, calc_start3} !== 10'b1000010000
            || {out_result2, gcd_a2, gcd_b2, out_result3, gcd_a3, gcd_b3} !== 192'd0) begin
            errors++;
            $display("FAIL reset_aux got ctrl %b want 1000010000", {in_ready2, out_valid2, out_timeout2, busy2, calc_start2, in_ready3, out_valid3, out_timeout3, busy3, calc_start3});
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_single();
        int n;
        int snap;
        exp_t e;
        out_ready = 1'b1;
        snap = cs1;
        sb.push_back('{res: 32'd6, tmo: 1'b0});
        issue1(32'd48, 32'd18);
        checks++;
        if (calc_start !== 1'b1 || busy !== 1'b1 || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL single_start got cs=%b busy=%b rdy=%b want 1/1/0", calc_start, busy, in_ready);
        end
        await1(300, n);
        checks++;
        if (out_valid !== 1'b1) begin
            errors++;
            $display("FAIL single_wait got no out_valid within %0d cycles", n);
        end else begin
            e = sb.pop_front();
            checks++;
            if (out_result !== e.res || out_timeout !== e.tmo) begin
                errors++;
                $display("FAIL single_result got %0d/%b want %0d/%b", out_result, out_timeout, e.res, e.tmo);
            end
            checks++;
            if (n < MIN_LAT) begin
                errors++;
                $display("FAIL single_latency got %0d want >= %0d", n, MIN_LAT);
            end
        end
        checks++;
        if (cs1 - snap != 2) begin
            errors++;
            $display("FAIL single_calc_start got %0d cycles want 2", cs1 - snap);
        end
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        int n;
        exp_t e;
        out_ready = 1'b1;
        sb.push_back('{res: 32'd6, tmo: 1'b0});
        sb.push_back('{res: 32'd7, tmo: 1'b0});
        for (int j = 0; j < 2; j++) begin
            if (j == 0) issue1(32'd48, 32'd18);
            else        issue1(32'd35, 32'd14);
            await1(300, n);
            checks++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
                errors++;
                $display("FAIL b2b_wait%0d got valid=%b rdy=%b want 1/0", j, out_valid, in_ready);
            end else begin
                e = sb.pop_front();
                checks++;
                if (out_result !== e.res || out_timeout !== e.tmo) begin
                    errors++;
                    $display("FAIL b2b_result%0d got %0d/%b want %0d/%b", j, out_result, out_timeout, e.res, e.tmo);
                end
            end
            @(negedge clk);
            checks++;
            if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
                errors++;
                $display("FAIL b2b_ready%0d got rdy=%b valid=%b want 1/0", j, in_ready, out_valid);
            end
        end
    endtask

    task automatic test_hold();
        int n;
        int snap;
        int bad;
        logic [31:0] held;
        exp_t e;
        out_ready = 1'b0;
        sb.push_back('{res: 32'd25, tmo: 1'b0});
        issue1(32'd100, 32'd75);
        await1(300, n);
        held = out_result;
        snap = cs1;
        in_valid = 1'b1; in_a = 32'd7; in_b = 32'd7;
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            checks++;
            if (out_valid !== 1'b1 || out_result !== held || in_ready !== 1'b0) begin
                errors++;
                bad++;
                if (bad < 3) $display("FAIL hold_cycle%0d got valid=%b res=%0d rdy=%b want 1/%0d/0", i, out_valid, out_result, in_ready, held);
            end
        end
        in_valid = 1'b0;
        e = sb.pop_front();
        checks++;
        if (out_result !== e.res || out_timeout !== e.tmo || gcd_a !== 32'd100 || cs1 != snap) begin
            errors++;
            $display("FAIL hold_result got %0d/%b a=%0d starts=%0d want %0d/%b a=100 starts=0", out_result, out_timeout, gcd_a, cs1 - snap, e.res, e.tmo);
        end
        out_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL hold_release got valid=%b rdy=%b want 0/1", out_valid, in_ready);
        end
    endtask

    task automatic test_stable_coincident();
        int n;
        exp_t e;
        toggle = 1'b0;
        const_val = 32'h0000_1234;
        out_ready2 = 1'b1;
        for (int j = 0; j < 2; j++) begin
            sb2.push_back('{res: 32'h0000_1234, tmo: 1'b0});
            in_a2 = 32'd12; in_b2 = 32'd8; in_valid2 = 1'b1;
            @(negedge clk);
            in_valid2 = 1'b0;
            n = 1;
            while (out_valid2 !== 1'b1 && n < 200) begin
                @(negedge clk);
                n++;
            end
            e = sb2.pop_front();
            checks++;
            if (n != MIN_LAT || out_valid3 !== 1'b1) begin
                errors++;
                $display("FAIL stable_latency%0d got %0d (v3=%b) want %0d", j, n, out_valid3, MIN_LAT);
            end
            checks++;
            if (out_result2 !== e.res || out_timeout2 !== e.tmo) begin
                errors++;
                $display("FAIL stable_result%0d got %h/%b want %h/%b", j, out_result2, out_timeout2, e.res, e.tmo);
            end
            checks++;
            if (out_result3 !== e.res || out_timeout3 !== e.tmo) begin
                errors++;
                $display("FAIL coincident%0d got %h/%b want %h/%b", j, out_result3, out_timeout3, e.res, e.tmo);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_timeout();
        int n;
        int n3;
        int snap;
        toggle = 1'b1;
        out_ready2 = 1'b0;
        snap = cs2;
        in_a2 = 32'd48; in_b2 = 32'd18; in_valid2 = 1'b1;
        @(negedge clk);
        in_a2 = 32'd5; in_b2 = 32'd5;
        n = 1;
        n3 = 0;
        while (out_valid2 !== 1'b1 && n < 200) begin
            if (out_valid3 === 1'b1 && n3 == 0) n3 = n;
            @(negedge clk);
            n++;
        end
        checks++;
        if (n != 67 || n3 != MIN_LAT) begin
            errors++;
            $display("FAIL timeout_latency got %0d/%0d want 67/%0d", n, n3, MIN_LAT);
        end
        checks++;
        if (out_timeout2 !== 1'b1 || out_timeout3 !== 1'b1 || out_result2[31:16] !== 16'hA5A5 || out_result3[31:16] !== 16'hA5A5) begin
            errors++;
            $display("FAIL timeout_flag got %b/%b res %h/%h want 1/1 A5A5xxxx", out_timeout2, out_timeout3, out_result2, out_result3);
        end
        checks++;
        if (gcd_a2 !== 32'd48 || gcd_b2 !== 32'd18 || cs2 - snap != 2 || busy2 !== 1'b1) begin
            errors++;
            $display("FAIL timeout_ignore got a=%0d b=%0d starts=%0d busy=%b want 48/18/2/1", gcd_a2, gcd_b2, cs2 - snap, busy2);
        end
        in_valid2 = 1'b0;
        out_ready2 = 1'b1;
        toggle = 1'b0;
        @(negedge clk);
        checks++;
        if (out_valid2 !== 1'b0 || out_valid3 !== 1'b0 || in_ready2 !== 1'b1 || in_ready3 !== 1'b1) begin
            errors++;
            $display("FAIL timeout_release got v=%b/%b rdy=%b/%b want 0/0/1/1", out_valid2, out_valid3, in_ready2, in_ready3);
        end
    endtask

    task automatic test_reset_mid();
        int n;
        exp_t e;
        out_ready = 1'b1;
        issue1(32'd48, 32'd18);
        repeat (5) @(negedge clk);
        checks++;
        if (busy !== 1'b1 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL midreset_pre got busy=%b valid=%b want 1/0", busy, out_valid);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if ({in_ready, out_valid, out_timeout, busy, calc_start} !== 5'b10000 || {out_result, gcd_a, gcd_b} !== 96'd0) begin
            errors++;
            $display("FAIL midreset_async got ctrl %b data %h/%h/%h want 10000 0/0/0", {in_ready, out_valid, out_timeout, busy, calc_start}, out_result, gcd_a, gcd_b);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        sb.push_back('{res: 32'd3, tmo: 1'b0});
        issue1(32'd9, 32'd6);
        await1(300, n);
        e = sb.pop_front();
        checks++;
        if (out_valid !== 1'b1 || out_result !== e.res || out_timeout !== e.tmo) begin
            errors++;
            $display("FAIL midreset_job got v=%b %0d/%b want 1 %0d/%b", out_valid, out_result, out_timeout, e.res, e.tmo);
        end
        @(negedge clk);
    endtask

    task automatic test_zero();
        int n;
        int snap;
        exp_t e;
        out_ready = 1'b1;
        for (int j = 0; j < 2; j++) begin
            snap = cs1;
            if (j == 0) begin
                sb.push_back('{res: 32'd25, tmo: 1'b0});
                issue1(32'd0, 32'd25);
            end else begin
                sb.push_back('{res: 32'd0, tmo: 1'b0});
                issue1(32'd0, 32'd0);
            end
            await1(300, n);
            e = sb.pop_front();
            checks++;
            if (out_valid !== 1'b1 || out_result !== e.res || out_timeout !== e.tmo) begin
                errors++;
                $display("FAIL zero_result%0d got v=%b %0d/%b want 1 %0d/%b", j, out_valid, out_result, out_timeout, e.res, e.tmo);
            end
`ifdef GCD_HOST_ZERO_BYPASS_EN
            checks++;
            if (n != 1 || cs1 != snap) begin
                errors++;
                $display("FAIL zero_bypass%0d got lat=%0d starts=%0d want 1/0", j, n, cs1 - snap);
            end
`else
            checks++;
            if (n < MIN_LAT || cs1 - snap != 2) begin
                errors++;
                $display("FAIL zero_core%0d got lat=%0d starts=%0d want >=%0d/2", j, n, cs1 - snap, MIN_LAT);
            end
`endif
            checks++;
            if (gcd_a !== 32'd0 || gcd_b !== e.res) begin
                errors++;
                $display("FAIL zero_operands%0d got %0d/%0d want 0/%0d", j, gcd_a, gcd_b, e.res);
            end
            @(negedge clk);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1);
    end

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_hold();
        test_stable_coincident();
        test_timeout();
        test_reset_mid();
        test_zero();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/rv32i_gcd_host_if.md
# rv32i_gcd_host_if

Host-side job controller that sits directly upstream of the RV32I core's GCD port. It accepts operand pairs over a valid/ready input channel and drives `gcd_a`, `gcd_b` and `calc_start` into the core. Because the core has no done signal, the block infers completion by watching `gcd_result` for stability. It returns each result, with a timeout flag, over a valid/ready output channel.

## Interface
Parameters:
- `START_CYCLES`, 2: number of cycles `calc_start` is held high per job (≥1).
- `MIN_CYCLES`, 8: minimum RUN cycles before a completion may be declared.
- `STABLE_CYCLES`, 16: number of consecutive unchanged `gcd_result` samples required to declare completion.
- `TIMEOUT_CYCLES`, 4096: RUN cycle budget; exceeding it forces a result.
- `CNT_W`, 16: counter width; must satisfy 2^CNT_W > TIMEOUT_CYCLES.

Ports (one clock; reset is asynchronous and active-low):
- `clk` input 1: system clock, shared with the core.
- `rst_n` input 1: asynchronous active-low reset.
- `in_valid` input 1: operand pair valid.
- `in_ready` output 1: block can accept a job.
- `in_a` input 32: operand A.
- `in_b` input 32: operand B.
- `out_valid` output 1: result valid.
- `out_ready` input 1: consumer accepts the result.
- `out_result` output 32: captured GCD.
- `out_timeout` output 1: result was forced by timeout; qualified by `out_valid`.
- `busy` output 1: job in flight (any state except IDLE).
- `calc_start` output 1: to the core.
- `gcd_a` output 32: to the core.
- `gcd_b` output 32: to the core.
- `gcd_result` input 32: from the core's registered result.

## Operation
- FSM states: IDLE, START, RUN, DONE. State encoding is free.
- **IDLE:**
  - `in_ready`=1.
  - On `in_valid & in_ready`: latch `in_a` into `gcd_a` and `in_b` into `gcd_b`, then go to START.
- **START:**
  - `calc_start`=1 for exactly START_CYCLES cycles, then go to RUN.
  - On RUN entry: clear `elapsed` and `stab`, and snapshot `gcd_result` into `prev`.
- **RUN:**
  - Each cycle: `elapsed`++.
  - If `gcd_result`==`prev`, `stab`++ (saturating); otherwise `stab`=0 and `prev`=`gcd_result`.
  - Completion: `elapsed` ≥ MIN_CYCLES and `stab` ≥ STABLE_CYCLES. Capture `gcd_result` into `out_result`, set `out_timeout`=0, go to DONE.
  - Timeout: `elapsed` == TIMEOUT_CYCLES without completion. Capture `gcd_result`, set `out_timeout`=1, go to DONE.
  - If completion and timeout fire in the same cycle, completion wins (`out_timeout`=0).
- **DONE:**
  - `out_valid`=1; `out_result` and `out_timeout` are held stable.
  - On `out_ready`: go to IDLE.
- `gcd_a` and `gcd_b` hold their last job's values until the next accept. They are not cleared on return to IDLE.
- No input buffering: at most one job is in flight. `in_ready`=0 in START, RUN and DONE.
- Operands are passed unmodified. All counters are unsigned.

## Timing
- Reset values:
  - state = IDLE.
  - `in_ready`=1.
  - `out_valid`=0, `out_timeout`=0, `busy`=0, `calc_start`=0.
  - `out_result`=0, `gcd_a`=0, `gcd_b`=0.
- All outputs are registered, except `in_ready` and `busy`, which decode state.
- An accept at edge N gives `calc_start`=1 for cycles N+1 … N+START_CYCLES.
- Minimum latency from accept to `out_valid`: START_CYCLES + max(MIN_CYCLES, STABLE_CYCLES) + 1 cycles.
- Back-to-back jobs:
  - Output handshake at edge M gives `in_ready`=1 in cycle M+1.
  - The earliest next accept is edge M+1.
- `out_valid` stays high indefinitely while `out_ready`=0.
- Reset asserted mid-job: immediate return to IDLE with all outputs at reset values; the in-flight result is discarded.
- A result equal to the previous job's value still completes via the stability rule. It is not a timeout.

## Configuration
- `GCD_HOST_ZERO_BYPASS_EN` defined:
  - On accept with `in_a`==0 or `in_b`==0, skip START and RUN and go straight to DONE.
  - `out_result` = the other operand (0 if both are zero), `out_timeout`=0, `calc_start` never asserted.
  - Latency: accept at edge N gives `out_valid` in cycle N+1.
  - `gcd_a` and `gcd_b` are still updated.
- Macro undefined: zero operands are sent to the core like any other job.

## Test plan
- Reset, then `in_a`=48, `in_b`=18 with the real core program → `calc_start` high for 2 cycles; later `out_valid`=1, `out_result`=6, `out_timeout`=0.
- Two back-to-back jobs (48,18), then (35,14), with `out_ready` tied to 1 → results 6 then 7; `in_ready` rises exactly 1 cycle after each output handshake.
- Core model that never updates `gcd_result` after a changing prefix, with TIMEOUT_CYCLES=64 → `out_valid` after RUN cycle 64 with `out_timeout`=1 only if stability was never reached; `in_valid` is ignored while `busy`=1.
- `out_ready` held 0 for 20 cycles after `out_valid` → `out_result` is stable, `in_ready`=0 throughout, and there is no second `calc_start`.
- `rst_n` pulsed low during RUN → all outputs return to reset values asynchronously; a fresh job (9,6) then returns 3.
- With `GCD_HOST_ZERO_BYPASS_EN`: job (0,25) → `out_result`=25 in the cycle after accept, `calc_start` never high; job (0,0) → `out_result`=0.
